// File: rtl/snic_pkg.sv
// Shared types and constants for the SNIC firmware loader: loader states,
// AXI response codes and the boot-control word address derivation.
package snic_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_LOAD_ACCEPT,
    ST_LOAD_WR,
    ST_LOAD_RESP,
    ST_BOOT_WR,
    ST_BOOT_RESP,
    ST_DONE,
    ST_ERR
  } fw_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] BOOT_HOLD_WORD = 32'h0000_0000;
  localparam logic [31:0] BOOT_RUN_WORD  = 32'h0000_0001;

  // The last IMEM word doubles as the core's boot-hold control register.
  function automatic logic [31:0] boot_addr(input logic [31:0] base,
                                            input logic [31:0] size);
    return base + size - 32'd4;
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite bundle (write channels only) used between the loader and the
// snic_rv IMEM host write port.
interface taxi_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport wr_mst (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport wr_slv (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/snic_axil_wr_single.sv
// One-shot AXI-Lite write engine: a req pulse launches AW and W together,
// sent flags the cycle both are accepted, ack flags the B response.
module snic_axil_wr_single (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        sent,
  output logic        ack,
  output logic [1:0]  resp,
  taxi_axil_if.wr_mst m_axil
);

  logic aw_pend;
  logic w_pend;
  logic b_pend;

  assign m_axil.awvalid = aw_pend;
  assign m_axil.wvalid  = w_pend;
  assign m_axil.bready  = b_pend;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.wstrb   = 4'hF;

  // Each channel counts as finished once it has handshaken, now or earlier.
  assign sent = (aw_pend || w_pend)
             && (!aw_pend || m_axil.awready)
             && (!w_pend  || m_axil.wready);
  assign ack  = b_pend && m_axil.bvalid;
  assign resp = m_axil.bresp;

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      b_pend  <= 1'b0;
    end else if (req) begin
      aw_pend <= 1'b1;
      w_pend  <= 1'b1;
    end else begin
      if (aw_pend && m_axil.awready) aw_pend <= 1'b0;
      if (w_pend && m_axil.wready)   w_pend  <= 1'b0;
      if (sent)                      b_pend  <= 1'b1;
      else if (ack)                  b_pend  <= 1'b0;
    end
  end

  always_ff @(posedge core_clk) begin
    if (req) begin
      m_axil.awaddr <= addr;
      m_axil.wdata  <= data;
    end
  end

endmodule

// File: rtl/snic_fw_loader.sv
// Streams a firmware image into snic_rv IMEM over AXI-Lite while holding the
// core in boot reset, then releases it through the boot-control word.
module snic_fw_loader
  import snic_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE       = 32'h0000_0000,
  parameter logic [31:0] IMEM_SIZE_BYTES = 32'h0001_0000
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        start,
  input  logic [31:0] s_fw_tdata,
  input  logic        s_fw_tvalid,
  output logic        s_fw_tready,
  input  logic        s_fw_tlast,
  taxi_axil_if.wr_mst m_axil_wr_imem,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] BOOT_ADDR = boot_addr(IMEM_BASE, IMEM_SIZE_BYTES);

  fw_state_e   state;
  logic [31:0] ptr;
  logic        fw_last;

  logic        fw_hs;
  logic        can_start;
  logic        overflow;
  logic        boot_go;
  logic        resp_ok;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_sent;
  logic        wr_ack;
  logic [1:0]  wr_resp;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fw_hs     = (state == ST_LOAD_ACCEPT) && s_fw_tvalid && s_fw_tready;
  assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign overflow  = (ptr == BOOT_ADDR);
  assign resp_ok   = (wr_resp == AXI_RESP_OKAY);
  assign boot_go   = (state == ST_LOAD_RESP) && wr_ack && resp_ok && fw_last;

  // Requests are launched on the deciding edge so AW/W are valid in the very
  // first cycle of HOLD, LOAD_WR and BOOT_WR.
  assign wr_req  = can_start || (fw_hs && !overflow) || boot_go;
  assign wr_addr = fw_hs ? ptr : BOOT_ADDR;
  assign wr_data = fw_hs ? s_fw_tdata : (boot_go ? BOOT_RUN_WORD : BOOT_HOLD_WORD);

  snic_axil_wr_single u_wr (
    .core_clk   (core_clk),
    .core_rst_n (core_rst_n),
    .req        (wr_req),
    .addr       (wr_addr),
    .data       (wr_data),
    .sent       (wr_sent),
    .ack        (wr_ack),
    .resp       (wr_resp),
    .m_axil     (m_axil_wr_imem)
  );

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state       <= ST_IDLE;
      ptr         <= IMEM_BASE;
      fw_last     <= 1'b0;
      word_count  <= 16'd0;
      s_fw_tready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_HOLD;
            ptr        <= IMEM_BASE;
            word_count <= 16'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (wr_ack) begin
            if (resp_ok) begin
              state       <= ST_LOAD_ACCEPT;
              s_fw_tready <= 1'b1;
            end else begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        ST_LOAD_ACCEPT: begin
          if (fw_hs) begin
            s_fw_tready <= 1'b0;
            fw_last     <= s_fw_tlast;
            // A word landing on the boot-control slot is swallowed, never written.
            if (overflow) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= ST_LOAD_WR;
            end
          end
        end
        ST_LOAD_WR: begin
          if (wr_sent) state <= ST_LOAD_RESP;
        end
        ST_LOAD_RESP: begin
          if (wr_ack) begin
            if (resp_ok) begin
              word_count <= sat_inc(word_count);
              ptr        <= ptr + 32'd4;
              if (fw_last) begin
                state <= ST_BOOT_WR;
              end else begin
                state       <= ST_LOAD_ACCEPT;
                s_fw_tready <= 1'b1;
              end
            end else begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        ST_BOOT_WR: begin
          if (wr_sent) state <= ST_BOOT_RESP;
        end
        ST_BOOT_RESP: begin
          if (wr_ack) begin
            busy <= 1'b0;
            if (resp_ok) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/snic_fw_loader.md
SNIC_FW_LOADER -- requirements
Module: snic_fw_loader

Interface
REQ-001 Parameter IMEM_BASE, default 32'h0000_0000, byte address of IMEM word 0.
REQ-002 Parameter IMEM_SIZE_BYTES, default 32'h0001_0000, IMEM span; BOOT_ADDR = IMEM_BASE + IMEM_SIZE_BYTES - 4.
REQ-003 core_clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-004 core_rst_n  input  1  reset is asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse begins a load session.
REQ-006 s_fw_tdata  input  32  firmware word, little-endian, in address order.
REQ-007 s_fw_tvalid / s_fw_tready / s_fw_tlast  in/out/in  1 each  firmware stream handshake; tlast marks final word.
REQ-008 m_axil_wr_imem  taxi_axil_if.wr_mst  32-bit addr/data  AXI-Lite write master into the snic_rv IMEM host write port.
REQ-009 busy  output  1  session in progress.
REQ-010 done  output  1  sticky; core released from boot hold.
REQ-011 error  output  1  sticky; session aborted.
REQ-012 word_count  output  16  words written to IMEM in current/last session.

Function
REQ-013 States: IDLE, HOLD, LOAD_ACCEPT, LOAD_WR, LOAD_RESP, BOOT_WR, BOOT_RESP, DONE, ERR.
REQ-014 IDLE: start -> HOLD next cycle; clear done, error, word_count, address pointer (= IMEM_BASE).
REQ-015 HOLD: write 32'h0 to BOOT_ADDR (core held in reset during load); OKAY response -> LOAD_ACCEPT.
REQ-016 LOAD_ACCEPT: s_fw_tready=1 only in this state; on tvalid&tready register tdata/tlast -> LOAD_WR.
REQ-017 LOAD_WR: awaddr=pointer, wdata=registered word, wstrb=4'hF, awprot=3'b000; awvalid and wvalid asserted together, each dropped independently after its own handshake; both done -> LOAD_RESP.
REQ-018 LOAD_RESP: bready=1; bvalid with bresp=OKAY -> word_count+1, pointer+4, then BOOT_WR if registered tlast else LOAD_ACCEPT; bresp!=OKAY -> ERR.
REQ-019 Overflow: word accepted when pointer == BOOT_ADDR -> ERR without issuing its write (max image IMEM_SIZE_BYTES/4-1 words).
REQ-020 BOOT_WR/BOOT_RESP: write 32'h1 to BOOT_ADDR; OKAY -> DONE, else ERR.
REQ-021 DONE: done=1, busy=0; ERR: error=1, busy=0; both return to IDLE only via start (start in DONE/ERR behaves as in IDLE).
REQ-022 busy=1 in HOLD..BOOT_RESP; start while busy ignored.
REQ-023 AXI-Lite master: valid never deasserted before handshake; address/data stable while valid; at most one write outstanding.
REQ-024 Single-word image (tlast on first word) legal: one IMEM write then boot write.
REQ-025 Zero-bubble handshakes: awready&wready high at first valid cycle -> LOAD_WR lasts 1 cycle; min 3 cycles/word with bvalid next cycle.
REQ-026 word_count saturates at 16'hFFFF.

Reset
REQ-027 core_rst_n low asynchronously forces IDLE; awvalid, wvalid, bready, s_fw_tready, busy, done, error = 0; word_count = 0; pointer = IMEM_BASE.
REQ-028 Reset mid-session abandons any outstanding write; no boot write issued afterwards.
REQ-029 Reset deassertion requires synchronised release upstream; block assumes clean deassertion.

Structure
REQ-030 State enum, BOOT_ADDR derivation and AXI response codes (OKAY=2'b00) in shared package snic_pkg.
REQ-031 One natural sub-module: snic_axil_wr_single (one-shot AXI-Lite write engine: addr/data in, req/ack/resp out), used for HOLD, LOAD and BOOT writes.

Verification
REQ-032 4-word image 0x11,0x22,0x33,0x44 (tlast on 4th) -> writes BOOT_ADDR=0, 0x0=0x11, 0x4=0x22, 0x8=0x33, 0xC=0x44, BOOT_ADDR=1; done=1, word_count=4.
REQ-033 bresp=SLVERR on 2nd word -> error=1, word_count=1, no further writes, no BOOT_ADDR=1 write.
REQ-034 IMEM_SIZE_BYTES=64: 15 words -> done; 16 words -> error after 15 writes, 16th never written.
REQ-035 awready delayed 3 cycles, wready immediate, random tvalid gaps -> each aw/w handshake occurs exactly once, data/address stable, image correct.
REQ-036 core_rst_n low during 3rd LOAD_WR -> all outputs at reset values immediately; subsequent start reloads full image and sets done.
REQ-037 start pulsed during LOAD -> ignored; session completes unchanged.
